// File: rtl/approx_mult_rr_arbiter.sv
// Round-robin front end sharing one pipelined approximate multiplier between NREQ requesters.
// Optional macro APPROX_ARB_EXACT_PRIO_EN: exact-mode requests win arbitration over approximate ones.
module approx_mult_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_exact,
  output logic                    mul_vld,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_recover,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_p,
  output logic                    idle
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      ptr_next;
  logic [PW:0]        ptr_inc;
  logic [NREQ-1:0]    cand;
  logic [NREQ-1:0]    grant;
  logic [PW-1:0]      grant_id;
  logic [NREQ-1:0]    handshake;
  logic               hs_any;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_exact;
  logic [PW-1:0]      issue_id_reg;
  logic [MUL_LAT-1:0] tag_valid;
  logic [PW-1:0]      tag_id [MUL_LAT];

`ifdef APPROX_ARB_EXACT_PRIO_EN
  logic [NREQ-1:0] exact_req;
  assign exact_req = req_valid & req_exact;
  assign cand      = (|exact_req) ? exact_req : req_valid;
`else
  assign cand = req_valid;
`endif

  // First candidate at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    logic [PW:0] idx_sum;
    logic        found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(NREQ))
        idx_sum = idx_sum - (PW+1)'(NREQ);
      if (!found && cand[idx_sum[PW-1:0]]) begin
        found                  = 1'b1;
        grant[idx_sum[PW-1:0]] = 1'b1;
        grant_id               = idx_sum[PW-1:0];
      end
    end
  end

  assign req_ready = grant & {NREQ{en & ~rst}};
  assign handshake = req_valid & req_ready;
  assign hs_any    = |handshake;

  assign ptr_inc  = {1'b0, grant_id} + (PW+1)'(1);
  assign ptr_next = (ptr_inc >= (PW+1)'(NREQ)) ? '0 : ptr_inc[PW-1:0];

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_exact = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_a     = req_a[k*WIDTH +: WIDTH];
        sel_b     = req_b[k*WIDTH +: WIDTH];
        sel_exact = req_exact[k];
      end
    end
  end

  // Operands hold their last values between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      mul_vld      <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_recover  <= 1'b0;
      issue_id_reg <= '0;
    end else begin
      mul_vld <= hs_any;
      if (hs_any) begin
        ptr_reg      <= ptr_next;
        mul_a        <= sel_a;
        mul_b        <= sel_b;
        mul_recover  <= sel_exact;
        issue_id_reg <= grant_id;
      end
    end
  end

  // Tag pipe tracks which requester owns the product emerging from the multiplier.
  for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid[0] <= 1'b0;
          tag_id[0]    <= '0;
        end else begin
          tag_valid[0] <= mul_vld;
          tag_id[0]    <= issue_id_reg;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid[gi] <= 1'b0;
          tag_id[gi]    <= '0;
        end else begin
          tag_valid[gi] <= tag_valid[gi-1];
          tag_id[gi]    <= tag_id[gi-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_p     <= '0;
    end else begin
      rsp_valid <= tag_valid[MUL_LAT-1] ? (NREQ'(1) << tag_id[MUL_LAT-1]) : '0;
      if (tag_valid[MUL_LAT-1])
        rsp_p <= mul_p;
    end
  end

  assign idle = ~|tag_valid & ~mul_vld & ~hs_any;

endmodule

// File: tb/tb_approx_mult_rr_arbiter.sv
// Directed bench for approx_mult_rr_arbiter; multiplier modelled as exact product delayed MUL_LAT.
// Expectations for the exact-priority case follow APPROX_ARB_EXACT_PRIO_EN.
module tb_approx_mult_rr_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_exact = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           mul_vld;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_recover;
  logic [2*W-1:0] mul_p;
  logic [N-1:0]   rsp_valid;
  logic [2*W-1:0] rsp_p;
  logic           idle;

  logic [2*W-1:0] mpipe [L];

  int n_cmp = 0;
  int n_err = 0;

  approx_mult_rr_arbiter #(.NREQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_exact(req_exact),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_recover(mul_recover),
    .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[L-1];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("%0t %s: %0h ok", $time, tag, obs);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int prod_tab [N] = '{20, 33, 48, 65};
  int a_tab    [N] = '{2, 3, 4, 5};

  initial begin
    // ---- 1: reset values and a single request ----
    en = 1'b1;
    nxt(); nxt();
    rst = 1'b0; #1;
    check_val("rst_mul_vld", 64'(mul_vld), 64'(0));
    check_val("rst_mul_a", 64'(mul_a), 64'(0));
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_val("rst_rsp_p", 64'(rsp_p), 64'(0));
    check_val("rst_idle", 64'(idle), 64'(1));
    nxt();
    set_ops(2, 16'd3, 16'd5);
    req_valid = 4'b0100; #1;
    check_val("t1_ready", 64'(req_ready), 64'(4'b0100));
    check_val("t1_idle_hs", 64'(idle), 64'(0));
    nxt(); req_valid = '0; #1;
    check_val("t1_mul_vld", 64'(mul_vld), 64'(1));
    check_val("t1_mul_a", 64'(mul_a), 64'(3));
    check_val("t1_mul_b", 64'(mul_b), 64'(5));
    check_val("t1_recover", 64'(mul_recover), 64'(0));
    for (int k = 2; k <= 4; k++) begin
      nxt(); #1;
      check_val("t1_no_rsp", 64'(rsp_valid), 64'(0));
    end
    nxt(); #1;
    check_val("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check_val("t1_rsp_p", 64'(rsp_p), 64'(15));
    nxt(); #1;
    check_val("t1_rsp_clear", 64'(rsp_valid), 64'(0));
    check_val("t1_rsp_hold", 64'(rsp_p), 64'(15));
    check_val("t1_idle", 64'(idle), 64'(1));

    // ---- 3: wrap from ptr=3 with only 0 and 1 requesting ----
    nxt();
    set_ops(0, 16'd7, 16'd9);
    set_ops(1, 16'd11, 16'd13);
    req_valid = 4'b0011; #1;
    check_val("t3_grant0", 64'(req_ready), 64'(4'b0001));
    nxt(); #1;
    check_val("t3_grant1", 64'(req_ready), 64'(4'b0010));
    check_val("t3_mul_a0", 64'(mul_a), 64'(7));
    nxt(); req_valid = '0; #1;
    check_val("t3_mul_a1", 64'(mul_a), 64'(11));
    for (int k = 3; k <= 7; k++) begin
      nxt(); #1;
      if (k == 5) begin
        check_val("t3_rsp0_v", 64'(rsp_valid), 64'(4'b0001));
        check_val("t3_rsp0_p", 64'(rsp_p), 64'(63));
      end else if (k == 6) begin
        check_val("t3_rsp1_v", 64'(rsp_valid), 64'(4'b0010));
        check_val("t3_rsp1_p", 64'(rsp_p), 64'(143));
      end else begin
        check_val("t3_no_rsp", 64'(rsp_valid), 64'(0));
      end
    end

    // ---- 2: reset gating, then round-robin over all four ----
    nxt();
    rst = 1'b1;
    req_valid = 4'hf;
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 2), W'(i + 10));
    #1;
    check_val("t2_rst_gate", 64'(req_ready), 64'(0));
    nxt();
    rst = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) nxt();
      req_valid = (k < 5) ? 4'hf : 4'h0;
      #1;
      check_val("t2_ready", 64'(req_ready), (k < 5) ? 64'(1 << (k % 4)) : 64'(0));
      if (k >= 1 && k <= 5)
        check_val("t2_mul_a", 64'(mul_a), 64'(a_tab[(k-1) % 4]));
      if (k >= 5 && k <= 9) begin
        check_val("t2_rsp_v", 64'(rsp_valid), 64'(1 << ((k-5) % 4)));
        check_val("t2_rsp_p", 64'(rsp_p), 64'(prod_tab[(k-5) % 4]));
      end else begin
        check_val("t2_no_rsp", 64'(rsp_valid), 64'(0));
      end
    end

    // ---- 4: two in flight, then en low with all requesting ----
    for (int k = 0; k <= 8; k++) begin
      nxt();
      req_valid = 4'hf;
      en = (k < 2);
      #1;
      check_val("t4_ready", 64'(req_ready), (k < 2) ? 64'(1 << (k + 1)) : 64'(0));
      if (k == 5) begin
        check_val("t4_rsp1_v", 64'(rsp_valid), 64'(4'b0010));
        check_val("t4_rsp1_p", 64'(rsp_p), 64'(33));
      end else if (k == 6) begin
        check_val("t4_rsp2_v", 64'(rsp_valid), 64'(4'b0100));
        check_val("t4_rsp2_p", 64'(rsp_p), 64'(48));
      end else begin
        check_val("t4_no_rsp", 64'(rsp_valid), 64'(0));
      end
      if (k >= 2 && k <= 4) check_val("t4_busy", 64'(idle), 64'(0));
      if (k == 7) check_val("t4_idle", 64'(idle), 64'(1));
    end

    // ---- 5: reset two cycles after the first of two issues ----
    for (int k = 0; k <= 9; k++) begin
      nxt();
      en = 1'b1;
      rst = (k == 2);
      req_valid = (k < 2) ? 4'hf : 4'h0;
      #1;
      if (k == 0) check_val("t5_grant3", 64'(req_ready), 64'(4'b1000));
      if (k == 1) check_val("t5_grant0", 64'(req_ready), 64'(4'b0001));
      if (k == 2) check_val("t5_rst_ready", 64'(req_ready), 64'(0));
      if (k == 3) begin
        check_val("t5_mul_vld", 64'(mul_vld), 64'(0));
        check_val("t5_mul_a", 64'(mul_a), 64'(0));
        check_val("t5_mul_b", 64'(mul_b), 64'(0));
        check_val("t5_rsp_p", 64'(rsp_p), 64'(0));
        check_val("t5_idle", 64'(idle), 64'(1));
      end
      if (k >= 3) check_val("t5_no_rsp", 64'(rsp_valid), 64'(0));
    end

    // ---- 6: exact vs approximate contention from ptr=0 ----
    nxt();
    req_valid = 4'b1011;
    req_exact = 4'b1000;
    #1;
`ifdef APPROX_ARB_EXACT_PRIO_EN
    check_val("t6_grant", 64'(req_ready), 64'(4'b1000));
`else
    check_val("t6_grant", 64'(req_ready), 64'(4'b0001));
`endif
    nxt();
    req_valid = 4'b0100;
    req_exact = 4'b0100;
    #1;
    check_val("t6_grant2", 64'(req_ready), 64'(4'b0100));
`ifdef APPROX_ARB_EXACT_PRIO_EN
    check_val("t6_recover", 64'(mul_recover), 64'(1));
    check_val("t6_mul_a", 64'(mul_a), 64'(5));
`else
    check_val("t6_recover", 64'(mul_recover), 64'(0));
    check_val("t6_mul_a", 64'(mul_a), 64'(2));
`endif
    nxt();
    req_valid = '0;
    req_exact = '0;
    #1;
    check_val("t6_recover2", 64'(mul_recover), 64'(1));
    check_val("t6_mul_a2", 64'(mul_a), 64'(4));
    for (int k = 3; k <= 7; k++) begin
      nxt(); #1;
      if (k == 5) begin
`ifdef APPROX_ARB_EXACT_PRIO_EN
        check_val("t6_rsp_v", 64'(rsp_valid), 64'(4'b1000));
        check_val("t6_rsp_p", 64'(rsp_p), 64'(65));
`else
        check_val("t6_rsp_v", 64'(rsp_valid), 64'(4'b0001));
        check_val("t6_rsp_p", 64'(rsp_p), 64'(20));
`endif
      end else if (k == 6) begin
        check_val("t6_rsp2_v", 64'(rsp_valid), 64'(4'b0100));
        check_val("t6_rsp2_p", 64'(rsp_p), 64'(48));
      end else begin
        check_val("t6_no_rsp", 64'(rsp_valid), 64'(0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
